fec_pn2112_xor: RTL and testbench
=================================

Name: fec_pn2112_xor

Overview:
Streaming 32-bit PN-2112 scrambler/descrambler for the 10GBASE-R FEC path (clause 74). It XORs each 2112-bit FEC block, carried as 66 32-bit words, with the PN-2112 sequence (x^58 + x^39 + 1). The LFSR restarts from the fixed seed at every block. It sits directly downstream of the FEC encoder (TX) or upstream of the FEC decoder (RX); the operation is its own inverse.

Parameters:
SEED, 58'h2aaaaaaaaaaaaaa, LFSR value loaded at every start of block.
WORDS, 66, words per FEC block (2112/32); fixed, not to be overridden.

Ports:
clk  in  1  single clock
srst_n  in  1  synchronous reset, active-low
in_data  in  32  block word; bit 0 is the first bit in time
in_valid  in  1  in_data valid
in_sob  in  1  marks word 0 of a block; qualified by in_valid
in_ready  out  1  accept; a transfer occurs when in_valid && in_ready
out_data  out  32  in_data XOR PN word
out_valid  out  1  out_data valid
out_sob  out  1  word 0 of a block
out_eob  out  1  word 65 of a block
out_ready  in  1  downstream accept
resync_err  out  1  one-cycle pulse: in_sob seen while word counter != 0
drop_cnt  out  16  saturating count of words discarded while unlocked

Behaviour:
- Reset (srst_n=0 at a clk edge):
  - out_valid=0, out_sob=0, out_eob=0, out_data=0, resync_err=0, drop_cnt=0.
  - lock=0, word counter=0, LFSR=SEED.
  - Reset mid-block abandons that block; no partial output follows.
- Handshake:
  - in_ready = !out_valid || out_ready (single output register, no skid).
  - Latency is 1 cycle from an accepted input to out_valid.
  - out_* hold stable while out_valid && !out_ready.
- LFSR, bit-serial definition:
  - out_bit = L[57] ^ L[38]; then L <= {L[56:0], out_bit}.
  - PN bit t of the block is the t-th out_bit produced after loading SEED.
  - PN word n bit j = PN bit 32n+j.
  - Implementation advances 32 steps per accepted word, computed in parallel in one cycle.
- Lock state machine (UNLOCKED, LOCKED):
  - UNLOCKED: an accepted word with in_sob=0 is discarded (in_ready stays high, nothing output) and drop_cnt increments, saturating at 16'hFFFF.
  - UNLOCKED: an accepted word with in_sob=1 goes to LOCKED and is processed as word 0.
  - LOCKED: each accepted word is XORed with PN word[counter]; counter increments.
  - At counter 65 the word is output with out_eob=1; counter wraps to 0 and the LFSR reloads SEED.
  - Word 0 is processed with the LFSR at SEED, so the word-0 mask is the first 32 PN bits.
- Boundary cases:
  - in_sob with counter==0 (normal case, including the first word after a wrap): no error.
  - in_sob with counter!=0: resync_err pulses the cycle after acceptance; the word is treated as word 0 (mask from SEED); counter=1 afterwards; the previous partial block is not padded.
  - in_sob on the word after eob: normal case, no error.
  - No in_sob while LOCKED at counter 0: the block continues unmarked, and out_sob=1 is still asserted on word 0.
  - Idle gaps (in_valid=0) do not advance the counter or the LFSR.

Test Plan:
1. Reset, then in_sob=1 with 66 words of 32'h0, out_ready=1 -> out_data word 0 = 32'hFFFFFFFF; word 1[6:0] = 7'h7F; all 66 words match the 66-entry PN-2112 golden table; out_sob on word 0, out_eob on word 65, resync_err=0.
2. Two back-to-back blocks of random data, then the outputs fed through a second instance -> original data recovered bit-exactly; block 2 mask identical to block 1.
3. Five words with in_sob=0 after reset, then a block -> drop_cnt=5, first output is word 0 = in_data ^ 32'hFFFFFFFF.
4. in_sob asserted again at word 20 -> resync_err pulses once; that word is XORed with 32'hFFFFFFFF; eob appears 65 words later.
5. out_ready toggled randomly plus in_valid gaps -> no loss or duplication; out_data stable while stalled; output stream equals test 1 results.
6. srst_n low at word 30, then a new block -> all outputs 0 during reset; new block word 0 mask is 32'hFFFFFFFF; drop_cnt=0.

Source files
------------

// File: rtl/fec_pn2112_xor.sv
// PN-2112 (x^58 + x^39 + 1) block scrambler/descrambler for the 10GBASE-R FEC path.
// Each 66-word block is XORed with the PN sequence restarted from SEED at word 0.
module fec_pn2112_xor #(
  parameter logic [57:0] SEED  = 58'h2aaaaaaaaaaaaaa,
  parameter int          WORDS = 66
) (
  input  logic        clk,
  input  logic        srst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_sob,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_sob,
  output logic        out_eob,
  input  logic        out_ready,
  output logic        resync_err,
  output logic [15:0] drop_cnt
);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;
  localparam logic [6:0] LAST        = 7'(WORDS - 1);

  logic [0:0]  state;
  logic [6:0]  cnt;
  logic [57:0] lfsr;
  logic        accept;
  logic        keep;
  logic [57:0] pn_src;
  logic [57:0] pn_next;
  logic [31:0] mask;

  // Handshake: a transfer happens when in_valid && in_ready; the single output
  // register may be refilled only when it is empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign keep     = in_sob || (state == ST_LOCKED);

  // A start-of-block word always takes its mask from SEED, even on a resync.
  assign pn_src = in_sob ? SEED : lfsr;

  always_comb begin
    logic [57:0] l;
    logic        b;
    l    = pn_src;
    b    = 1'b0;
    mask = '0;
    for (int i = 0; i < 32; i++) begin
      b       = l[57] ^ l[38];
      mask[i] = b;
      l       = {l[56:0], b};
    end
    pn_next = l;
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state      <= ST_UNLOCKED;
      cnt        <= '0;
      lfsr       <= SEED;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sob    <= 1'b0;
      out_eob    <= 1'b0;
      resync_err <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      resync_err <= 1'b0;
      if (accept) begin
        if (keep) begin
          state      <= ST_LOCKED;
          out_valid  <= 1'b1;
          out_data   <= in_data ^ mask;
          out_sob    <= in_sob || (cnt == '0);
          out_eob    <= !in_sob && (cnt == LAST);
          resync_err <= in_sob && (cnt != '0);
          if (!in_sob && (cnt == LAST)) begin
            cnt  <= '0;
            lfsr <= SEED;
          end else begin
            cnt  <= in_sob ? 7'd1 : cnt + 7'd1;
            lfsr <= pn_next;
          end
        end else begin
          // Unlocked and not a block start: swallow the word.
          out_valid <= 1'b0;
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fec_pn2112_xor.sv
// Bench for fec_pn2112_xor: directed vector table, then randomized blocks
// checked against a PN-sequence model built from the recurrence s[t]=s[t-58]^s[t-39].
module tb_fec_pn2112_xor;

  localparam logic [57:0] SEED  = 58'h2aaaaaaaaaaaaaa;
  localparam int          WORDS = 66;

  logic        clk = 1'b0;
  logic        srst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_sob = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid, out_sob, out_eob, dut_out_ready, resync_err;
  logic [15:0] drop_cnt;

  logic        inv_in_valid, inv_in_ready;
  logic [31:0] inv_out_data;
  logic        inv_out_valid, inv_out_sob, inv_out_eob, inv_resync_err;
  logic [15:0] inv_drop_cnt;

  logic tb_ready = 1'b1;
  logic chain = 1'b0;
  logic rand_ready = 1'b0;
  logic rand_gaps = 1'b0;
  logic mon_en = 1'b0;

  int checks = 0;
  int errors = 0;

  assign dut_out_ready = chain ? inv_in_ready : tb_ready;
  assign inv_in_valid  = chain & out_valid;

  logic [31:0] mon_data;
  logic        mon_valid, mon_sob, mon_eob;
  assign mon_data  = chain ? inv_out_data  : out_data;
  assign mon_valid = chain ? inv_out_valid : out_valid;
  assign mon_sob   = chain ? inv_out_sob   : out_sob;
  assign mon_eob   = chain ? inv_out_eob   : out_eob;

  fec_pn2112_xor u_dut (
    .clk(clk), .srst_n(srst_n),
    .in_data(in_data), .in_valid(in_valid), .in_sob(in_sob), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_sob(out_sob), .out_eob(out_eob),
    .out_ready(dut_out_ready), .resync_err(resync_err), .drop_cnt(drop_cnt)
  );

  fec_pn2112_xor u_inv (
    .clk(clk), .srst_n(srst_n),
    .in_data(out_data), .in_valid(inv_in_valid), .in_sob(out_sob), .in_ready(inv_in_ready),
    .out_data(inv_out_data), .out_valid(inv_out_valid), .out_sob(inv_out_sob),
    .out_eob(inv_out_eob), .out_ready(tb_ready), .resync_err(inv_resync_err),
    .drop_cnt(inv_drop_cnt)
  );

  // ---------------- clock / ready generation ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    tb_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  bit          pn [0:WORDS*32-1];
  logic [31:0] pn_word [0:WORDS-1];
  logic [57:0] seed_v = SEED;
  bit          m_lock;
  int          m_idx, m_drop, m_resync;
  logic [33:0] exp_q[$];

  // Bits before t=0 are the seed register contents: L[k] is "bit -1-k".
  function automatic bit pn_at(input int t);
    if (t < 0) return seed_v[6'(-1 - t)];
    return pn[t];
  endfunction

  task automatic build_pn();
    for (int t = 0; t < WORDS * 32; t++) pn[t] = pn_at(t - 58) ^ pn_at(t - 39);
    for (int n = 0; n < WORDS; n++)
      for (int j = 0; j < 32; j++) pn_word[n][j] = pn[32 * n + j];
  endtask

  task automatic model_accept(input logic [31:0] d, input logic s);
    logic [31:0] x;
    if (s) begin
      if (m_lock && m_idx != 0) m_resync++;
      m_lock = 1'b1;
      m_idx  = 0;
    end
    if (!m_lock) begin
      if (m_drop < 65535) m_drop++;
      return;
    end
    x = chain ? d : (d ^ pn_word[m_idx]);
    exp_q.push_back({m_idx == 0, m_idx == WORDS - 1, x});
    m_idx = (m_idx + 1) % WORDS;
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [33:0] held, got, exp_v;
  bit          stall_prev = 1'b0;
  int          resync_seen = 0;
  int          resync_base = 0;

  always @(negedge clk) begin
    if (!srst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (resync_err) resync_seen++;
      if (mon_en) begin
        got = {mon_sob, mon_eob, mon_data};
        if (stall_prev) begin
          checks++;
          if (!mon_valid || got != held) begin
            errors++;
            $display("FAIL stall_hold: got valid=%b %h required valid=1 %h", mon_valid, got, held);
          end
        end
        if (mon_valid && tb_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got %h required no output", got);
          end else begin
            exp_v = exp_q.pop_front();
            if (got != exp_v) begin
              errors++;
              $display("FAIL out_word: got {sob,eob,data}=%h required %h", got, exp_v);
            end
          end
        end
        stall_prev = mon_valid && !tb_ready;
        held = got;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, expv);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic s);
    bit rdy;
    bit done = 1'b0;
    if (rand_gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    in_data  = d;
    in_sob   = s;
    in_valid = 1'b1;
    for (int n = 0; n < 300 && !done; n++) begin
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        model_accept(d, s);
        done = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_sob   = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: got no accept required accept within 300 cycles");
    end
  endtask

  task automatic send_block(input int n_words, input bit first_sob, input bit zero);
    for (int i = 0; i < n_words; i++)
      send(zero ? 32'h0 : $urandom(), first_sob && i == 0);
  endtask

  task automatic do_reset();
    srst_n   = 1'b0;
    in_valid = 1'b0;
    in_sob   = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_sob", 32'(out_sob), 32'h0);
      chk("rst_out_eob", 32'(out_eob), 32'h0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_resync_err", 32'(resync_err), 32'h0);
      chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    end
    exp_q.delete();
    m_lock = 1'b0;
    m_idx = 0;
    m_drop = 0;
    m_resync = 0;
    resync_base = resync_seen;
    srst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d words pending required 0", name, exp_q.size());
    end
    chk({name, "_resync"}, 32'(resync_seen - resync_base), 32'(m_resync));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] din;
    logic        sob;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_sob;
    logic        exp_resync;
  } vec_t;

  vec_t tbl [0:7];

  initial begin
    // Word-0 mask is all ones, word 1 is 02AAAAFF, word 2 is AAAA8000.
    tbl[0] = '{32'h12345678, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0};
    tbl[1] = '{32'hDEADBEEF, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0};
    tbl[2] = '{32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0};
    tbl[3] = '{32'h00000000, 1'b0, 1'b1, 32'h02AAAAFF, 1'b0, 1'b0};
    tbl[4] = '{32'hFFFFFFFF, 1'b0, 1'b1, 32'h55557FFF, 1'b0, 1'b0};
    tbl[5] = '{32'hA5A5A5A5, 1'b1, 1'b1, 32'h5A5A5A5A, 1'b1, 1'b1};
    tbl[6] = '{32'h00000000, 1'b0, 1'b1, 32'h02AAAAFF, 1'b0, 1'b0};
    tbl[7] = '{32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b1};

    build_pn();
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 8; i++) begin
      in_data  = tbl[i].din;
      in_sob   = tbl[i].sob;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_sob   = 1'b0;
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d_data", i), out_data, tbl[i].exp_data);
        chk($sformatf("tbl%0d_sob", i), 32'(out_sob), 32'(tbl[i].exp_sob));
        chk($sformatf("tbl%0d_eob", i), 32'(out_eob), 32'h0);
      end
      chk($sformatf("tbl%0d_resync", i), 32'(resync_err), 32'(tbl[i].exp_resync));
    end
    @(negedge clk);
    chk("tbl_drop_cnt", 32'(drop_cnt), 32'd2);

    // Zero block: output is the raw PN-2112 sequence.
    do_reset();
    mon_en = 1'b1;
    send_block(WORDS, 1'b1, 1'b1);
    drain("t1");

    // Two random blocks through a second instance must come back unchanged.
    do_reset();
    chain = 1'b1;
    rand_ready = 1'b1;
    send_block(WORDS, 1'b1, 1'b0);
    send_block(WORDS, 1'b1, 1'b0);
    drain("t2");
    rand_ready = 1'b0;
    repeat (2) @(negedge clk);
    chain = 1'b0;

    // Words before the first block start are dropped and counted.
    do_reset();
    send_block(5, 1'b0, 1'b0);
    send_block(WORDS, 1'b1, 1'b0);
    drain("t3");
    chk("t3_drop_cnt", 32'(drop_cnt), 32'd5);

    // Resync at word 20: that word restarts the block.
    do_reset();
    send_block(20, 1'b1, 1'b0);
    send_block(WORDS, 1'b1, 1'b0);
    drain("t4");
    chk("t4_resync_once", 32'(resync_seen - resync_base), 32'd1);

    // Backpressure and gaps; second block carries no sob marker.
    do_reset();
    rand_ready = 1'b1;
    rand_gaps = 1'b1;
    send_block(WORDS, 1'b1, 1'b1);
    send_block(WORDS, 1'b0, 1'b1);
    drain("t5");
    rand_ready = 1'b0;
    rand_gaps = 1'b0;

    // Reset in the middle of a block, then a fresh block.
    do_reset();
    send_block(30, 1'b1, 1'b0);
    do_reset();
    send_block(WORDS, 1'b1, 1'b0);
    drain("t6");
    chk("t6_drop_cnt", 32'(drop_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
